// File: rtl/sat_ctrl.sv
// Saturation controller: clamps a signed sample to a run-time limit, applies limit
// changes on sample boundaries, and drives an anti-windup freeze. Optional: SAT_CTRL_STICKY_EN.
module sat_ctrl #(
  parameter int unsigned RI = 15,
  parameter int unsigned RO = 14,
  parameter int unsigned LW = 4,
  parameter int unsigned HW = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic signed [RI-1:0] in,
  input  logic                 lim_req,
  input  logic [LW-1:0]        lim_val,
  output logic                 lim_busy,
  output logic                 lim_ack,
  input  logic [HW-1:0]        hold_n,
  input  logic [HW-1:0]        rel_n,
  input  logic                 cnt_clr,
  output logic signed [RO-1:0] out,
  output logic                 out_valid,
  output logic                 pos_sat,
  output logic                 neg_sat,
  output logic                 freeze,
  output logic [15:0]          sat_cnt,
  output logic                 pos_stky,
  output logic                 neg_stky
);

  localparam int unsigned XW = RI + 1;
  localparam logic [LW-1:0] LIM_MAX = LW'(RO - 1);
  localparam logic [HW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_RUN, ST_ARMED, ST_FREEZE, ST_RECOVER} state_e;

  state_e           state_q, state_d;
  logic [HW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             freeze_q, freeze_d;
  logic [LW-1:0]    lim_q, lim_d, pend_q, pend_d, lim_cap;
  logic             busy_q, busy_d, ack_q, ack_d;
  logic signed [RO-1:0] out_q;
  logic             ovld_q, pos_q, neg_q;
  logic [15:0]      scnt_q;

  logic [XW-1:0]        pow_x;
  logic signed [XW-1:0] in_x, hi_x, lo_x;
  logic                 pos_c, neg_c, sat_c;
  logic signed [RO-1:0] clamp_c;

  // Limit range is [-2^L, 2^L-1], compared one bit wider than the input
  always_comb begin
    pow_x   = XW'(1) << lim_q;
    hi_x    = $signed(pow_x - XW'(1));
    lo_x    = $signed(-pow_x);
    in_x    = XW'(in);
    pos_c   = in_x > hi_x;
    neg_c   = in_x < lo_x;
    sat_c   = pos_c | neg_c;
    clamp_c = pos_c ? RO'(hi_x) : (neg_c ? RO'(lo_x) : RO'(in));
  end

  assign lim_cap = (lim_val > LIM_MAX) ? LIM_MAX : lim_val;

  // Pending limit is applied by the first sample seen while busy
  always_comb begin
    lim_d  = lim_q;
    pend_d = pend_q;
    busy_d = busy_q;
    ack_d  = 1'b0;
    if (!busy_q && lim_req) begin
      pend_d = lim_cap;
      busy_d = 1'b1;
    end else if (busy_q && in_valid) begin
      lim_d  = pend_q;
      busy_d = 1'b0;
      ack_d  = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      freeze_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      freeze_q <= freeze_d;
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + HW'(1);

  // Next-state: advances only on a sample
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_valid) begin
      unique case (state_q)
        ST_RUN: if (sat_c) begin
          if (hold_n <= HW'(1)) begin state_d = ST_FREEZE; cnt_d = '0; end
          else begin state_d = ST_ARMED; cnt_d = HW'(1); end
        end
        ST_ARMED: if (sat_c) begin
          if (cnt_inc >= hold_n) begin state_d = ST_FREEZE; cnt_d = '0; end
          else cnt_d = cnt_inc;
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
        ST_FREEZE: if (!sat_c) begin
          if (rel_n <= HW'(1)) begin state_d = ST_RUN; cnt_d = '0; end
          else begin state_d = ST_RECOVER; cnt_d = HW'(1); end
        end
        ST_RECOVER: if (sat_c) begin
          state_d = ST_FREEZE;
          cnt_d   = '0;
        end else if (cnt_inc >= rel_n) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
        default: begin state_d = ST_RUN; cnt_d = '0; end
      endcase
    end
  end

  // Output decode, registered alongside the state
  always_comb begin
    freeze_d = (state_d == ST_FREEZE) || (state_d == ST_RECOVER);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lim_q  <= LIM_MAX;
      pend_q <= '0;
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
      out_q  <= '0;
      ovld_q <= 1'b0;
      pos_q  <= 1'b0;
      neg_q  <= 1'b0;
      scnt_q <= '0;
    end else begin
      lim_q  <= lim_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      ack_q  <= ack_d;
      ovld_q <= in_valid;
      if (in_valid) begin
        out_q <= clamp_c;
        pos_q <= pos_c;
        neg_q <= neg_c;
      end
      if (cnt_clr) scnt_q <= '0;
      else if (in_valid && sat_c && scnt_q != 16'hFFFF) scnt_q <= scnt_q + 16'd1;
    end
  end

`ifdef SAT_CTRL_STICKY_EN
  logic pstk_q, nstk_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pstk_q <= 1'b0;
      nstk_q <= 1'b0;
    end else if (cnt_clr) begin
      pstk_q <= 1'b0;
      nstk_q <= 1'b0;
    end else if (in_valid) begin
      pstk_q <= pstk_q | pos_c;
      nstk_q <= nstk_q | neg_c;
    end
  end
  assign pos_stky = pstk_q;
  assign neg_stky = nstk_q;
`else
  assign pos_stky = 1'b0;
  assign neg_stky = 1'b0;
`endif

  assign lim_busy  = busy_q;
  assign lim_ack   = ack_q;
  assign out       = out_q;
  assign out_valid = ovld_q;
  assign pos_sat   = pos_q;
  assign neg_sat   = neg_q;
  assign freeze    = freeze_q;
  assign sat_cnt   = scnt_q;

endmodule

// File: tb/tb_sat_ctrl.sv
// Directed self-checking bench for sat_ctrl: clamp table, limit handshake,
// anti-windup sequences, counter saturation and asynchronous reset.
module tb_sat_ctrl;

  logic               clk, rstn, in_valid, lim_req, cnt_clr;
  logic signed [14:0] in;
  logic [3:0]         lim_val;
  logic [7:0]         hold_n, rel_n;
  logic               lim_busy, lim_ack, out_valid, pos_sat, neg_sat, freeze;
  logic signed [13:0] out;
  logic [15:0]        sat_cnt;
  logic               pos_stky, neg_stky;

  int n_checks = 0;
  int n_err    = 0;
  int exp_cnt  = 0;
  int exp_stky = 0;

  typedef struct {
    logic signed [14:0] din;
    int                 exp_out;
    bit                 exp_pos;
    bit                 exp_neg;
  } vec_t;

  vec_t tbl[8];

  sat_ctrl dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in(in),
    .lim_req(lim_req), .lim_val(lim_val), .lim_busy(lim_busy), .lim_ack(lim_ack),
    .hold_n(hold_n), .rel_n(rel_n), .cnt_clr(cnt_clr),
    .out(out), .out_valid(out_valid), .pos_sat(pos_sat), .neg_sat(neg_sat),
    .freeze(freeze), .sat_cnt(sat_cnt), .pos_stky(pos_stky), .neg_stky(neg_stky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_sample(input logic signed [14:0] v);
    in       = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic req_limit(input logic [3:0] v);
    lim_req = 1'b1;
    lim_val = v;
    @(posedge clk);
    #1;
    lim_req = 1'b0;
  endtask

  initial begin
    tbl[0] = '{15'sd9000,   8191, 1'b1, 1'b0};
    tbl[1] = '{-15'sd9000, -8192, 1'b0, 1'b1};
    tbl[2] = '{-15'sd5,       -5, 1'b0, 1'b0};
    tbl[3] = '{15'sd8191,   8191, 1'b0, 1'b0};
    tbl[4] = '{15'sd8192,   8191, 1'b1, 1'b0};
    tbl[5] = '{-15'sd8192, -8192, 1'b0, 1'b0};
    tbl[6] = '{-15'sd8193, -8192, 1'b0, 1'b1};
    tbl[7] = '{15'sd0,         0, 1'b0, 1'b0};
`ifdef SAT_CTRL_STICKY_EN
    exp_stky = 1;
`endif

    rstn = 1'b0; in_valid = 1'b0; in = '0; lim_req = 1'b0; lim_val = '0;
    hold_n = 8'd255; rel_n = 8'd1; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    idle();
    check("rst_out", int'(out), 0);
    check("rst_flags", {out_valid, pos_sat, neg_sat, freeze, lim_busy, lim_ack}, 0);
    check("rst_sat_cnt", int'(sat_cnt), 0);

    // Clamp table at the default limit L=13
    for (int i = 0; i < 8; i++) begin
      do_sample(tbl[i].din);
      if (tbl[i].exp_pos || tbl[i].exp_neg) exp_cnt++;
      check($sformatf("tbl%0d_out", i), int'(out), tbl[i].exp_out);
      check($sformatf("tbl%0d_pos", i), int'(pos_sat), int'(tbl[i].exp_pos));
      check($sformatf("tbl%0d_neg", i), int'(neg_sat), int'(tbl[i].exp_neg));
      check($sformatf("tbl%0d_vld", i), int'(out_valid), 1);
      check($sformatf("tbl%0d_cnt", i), int'(sat_cnt), exp_cnt);
    end
    idle();
    check("vld_pulse", int'(out_valid), 0);

    // Limit handshake: L=7 applied by the next sample, effective one sample later
    req_limit(4'd7);
    check("lim_busy_set", int'(lim_busy), 1);
    idle();
    check("lim_busy_wait", int'(lim_busy), 1);
    do_sample(15'sd200);
    check("lim_old_out", int'(out), 200);
    check("lim_ack", int'(lim_ack), 1);
    check("lim_busy_clr", int'(lim_busy), 0);
    idle();
    check("lim_ack_pulse", int'(lim_ack), 0);
    do_sample(15'sd200);
    check("lim7_out", int'(out), 127);
    check("lim7_pos", int'(pos_sat), 1);
    idle();
    check("pos_hold", int'(pos_sat), 1);
    check("out_hold", int'(out), 127);

    // L=0 range [-1,0]; a second request while busy is dropped
    req_limit(4'd0);
    req_limit(4'd3);
    do_sample(15'sd0);
    do_sample(15'sd5);
    check("lim0_pos_out", int'(out), 0);
    do_sample(-15'sd5);
    check("lim0_neg_out", int'(out), -1);
    check("lim0_neg", int'(neg_sat), 1);

    // Code 15 is coerced to 13
    req_limit(4'd15);
    do_sample(15'sd0);
    do_sample(15'sd9000);
    check("lim15_out", int'(out), 8191);

    // Anti-windup, hold_n=3 rel_n=2
    hold_n = 8'd3; rel_n = 8'd2;
    do_sample(15'sd0);
    check("fsm_run", int'(freeze), 0);
    do_sample(15'sd9000);
    check("fsm_sat1", int'(freeze), 0);
    do_sample(15'sd9000);
    check("fsm_sat2", int'(freeze), 0);
    do_sample(15'sd9000);
    check("fsm_sat3", int'(freeze), 1);
    do_sample(15'sd0);
    check("fsm_rec1", int'(freeze), 1);
    do_sample(-15'sd9000);
    check("fsm_resat", int'(freeze), 1);
    do_sample(15'sd0);
    check("fsm_rec2", int'(freeze), 1);
    do_sample(15'sd0);
    check("fsm_release", int'(freeze), 0);

    // hold_n=0 freezes on the first saturated sample
    hold_n = 8'd0;
    do_sample(15'sd9000);
    check("hold0_freeze", int'(freeze), 1);
    check("hold0_vld", int'(out_valid), 1);

    // Drive sat_cnt into saturation
    in = 15'sd9000;
    in_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1 in_valid = 1'b0;
    check("cnt_sat", int'(sat_cnt), 65535);
    check("stky_pos", int'(pos_stky), exp_stky);
    check("stky_neg", int'(neg_stky), exp_stky);
    cnt_clr = 1'b1;
    do_sample(15'sd9000);
    cnt_clr = 1'b0;
    check("cnt_clr", int'(sat_cnt), 0);
    check("stky_pos_clr", int'(pos_stky), 0);
    check("stky_neg_clr", int'(neg_stky), 0);

    // Asynchronous reset while frozen with a limit pending
    req_limit(4'd5);
    check("pre_rst_busy", int'(lim_busy), 1);
    check("pre_rst_freeze", int'(freeze), 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_freeze", int'(freeze), 0);
    check("arst_busy", int'(lim_busy), 0);
    check("arst_out", int'(out), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    do_sample(15'sd9000);
    check("post_rst_out", int'(out), 8191);
    check("post_rst_cnt", int'(sat_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
